// File: rtl/moving_average_filter.sv
// moving_average_filter: running-sum boxcar mean of the last 2^LOG2_TAPS samples (MOVAVG_ROUND_EN selects round-half-up output)
module moving_average_filter #(
  parameter int DATA_W    = 12,
  parameter int LOG2_TAPS = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              settled_o
);
  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int AW   = DATA_W + LOG2_TAPS + 1;
  localparam int CW   = LOG2_TAPS + 1;
  logic [DATA_W-1:0]    buf_q [TAPS];
  logic [LOG2_TAPS-1:0] wr_q;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, out_valid_q, settled_q;
  logic [DATA_W-1:0]    out_q, avg;
  // running sum adds the new sample and retires the one it overwrites; fill count saturates at TAPS
  always_comb begin
    acc_d = acc_q + {{(LOG2_TAPS+1){in_data_i[DATA_W-1]}}, in_data_i}
                  - {{(LOG2_TAPS+1){buf_q[wr_q][DATA_W-1]}}, buf_q[wr_q]};
    cnt_d = (cnt_q == CW'(TAPS)) ? cnt_q : cnt_q + CW'(1);
  end
`ifdef MOVAVG_ROUND_EN
  logic [DATA_W:0] rnd;
  // adding the bit just below the binary point to the floored quotient rounds half up
  assign rnd = acc_q[AW-1:LOG2_TAPS] + (DATA_W+1)'(acc_q[LOG2_TAPS-1]);
  assign avg = (rnd[DATA_W:DATA_W-1] == 2'b01) ? {1'b0, {(DATA_W-1){1'b1}}} : rnd[DATA_W-1:0];
`else
  assign avg = acc_q[DATA_W+LOG2_TAPS-1:LOG2_TAPS];
`endif
  // reset and clear both return to the empty state; otherwise accept samples and register the average a cycle later
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
      wr_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      settled_q   <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
      wr_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      settled_q   <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      pend_q      <= in_valid_i;
      out_valid_q <= pend_q;
      if (pend_q) out_q <= avg;
      if (in_valid_i) begin
        buf_q[wr_q] <= in_data_i;
        wr_q        <= wr_q + LOG2_TAPS'(1);
        acc_q       <= acc_d;
        cnt_q       <= cnt_d;
        settled_q   <= (cnt_d == CW'(TAPS));
      end
    end
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;
  assign settled_o   = settled_q;
endmodule

// File: doc/moving_average_filter.md
# moving_average_filter

Parametrised boxcar (moving-average) FIR for the PLL loop-filter and phase-detector smoothing path. It computes the mean of the last 2^LOG2_TAPS accepted signed samples using a circular buffer and a running-sum accumulator, instead of an adder tree. It supports gapped input through a valid strobe, a synchronous flush and a warm-up status flag. It sits between the phase detector output and the loop filter.

## Interface
- DATA_W, 12: signed sample width in and out (2..32).
- LOG2_TAPS, 4: log2 of tap count, so TAPS = 2^LOG2_TAPS (1..8, i.e. 2..256 taps).
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of history, accumulator and status.
- in_valid  in  1  in_data is accepted at the next rising edge.
- in_data  in  DATA_W  signed two's-complement sample.
- out_valid  out  1  one-cycle pulse per averaged result.
- out_data  out  DATA_W  signed average, held between pulses.
- settled  out  1  high once TAPS samples have been accepted since reset or clear.

## Operation
- State:
  - buffer of TAPS x DATA_W registers;
  - wr_ptr, LOG2_TAPS bits;
  - acc, signed, DATA_W+LOG2_TAPS+1 bits;
  - fill count, LOG2_TAPS+1 bits, saturating at TAPS.
- Accept (in_valid=1, clear=0):
  - acc <= acc + in_data − buffer[wr_ptr], with the oldest sample sign-extended;
  - buffer[wr_ptr] <= in_data;
  - wr_ptr increments and wraps from TAPS−1 to 0;
  - count increments until it reaches TAPS.
- Output stage, one cycle after an accept:
  - out_data <= acc arithmetic-shifted right by LOG2_TAPS;
  - out_valid <= 1.
  - In every other cycle out_valid <= 0 and out_data holds.
- Warm-up: the buffer starts at zero, so early outputs are floor(sum of k samples / TAPS) and are not divided by k.
- Width: the sum of TAPS samples always fits in DATA_W+LOG2_TAPS bits, so the accumulator cannot overflow. The extra bit exists only for rounding headroom.
- The result always lies within [−2^(DATA_W−1), 2^(DATA_W−1)−1]. No saturation is needed except as noted under Configuration.
- settled = (count == TAPS). It is registered, and rises in the same edge that accepts the TAPS-th sample.
- clear=1 at an edge:
  - zeroes buffer, acc, wr_ptr, count, settled, out_data and out_valid;
  - takes priority over a simultaneous in_valid, so that sample is dropped;
  - cancels a result pending in the output stage, so no out_valid follows.
- reset: the same effect as clear, applied asynchronously. Releasing reset mid-stream restarts warm-up.

## Timing
- Reset values:
  - out_valid=0, out_data=0, settled=0;
  - all internal state 0.
- Latency: in_valid sampled high at edge k gives out_valid high in the cycle after edge k+1, i.e. a 2-cycle latency.
- Throughput: one sample per clock; back-to-back in_valid is fully supported.
- Gaps: in_valid=0 leaves buffer, acc, wr_ptr and count unchanged. out_valid pulses exactly once per accepted sample, in order.
- No backpressure: the downstream block must accept every out_valid pulse.

## Configuration
- MOVAVG_ROUND_EN defined:
  - out_data = (acc + 2^(LOG2_TAPS−1)) >>> LOG2_TAPS, i.e. round half toward +infinity;
  - then clamp to 2^(DATA_W−1)−1.
- MOVAVG_ROUND_EN undefined: out_data = acc >>> LOG2_TAPS, i.e. floor (truncation toward −infinity). This is the default.
- Latency, ports and all other behaviour are identical in both builds.

## Test plan
All cases use DATA_W=12 and LOG2_TAPS=4 (TAPS=16) unless stated.
- Reset: assert reset asynchronously mid-stream -> out_valid=0, out_data=0, settled=0 immediately; the first accept after release outputs floor(x/16).
- Constant 100 each cycle (truncating build):
  - out_data sequence 6, 12, 18, 25, … reaches 100 on the 16th result and holds 100 afterwards;
  - settled rises with the 16th accept;
  - each out_valid follows its accept by 2 cycles.
- Extremes: 16×2047 gives out=2047; then 16×(−2048) ramps down to out=−2048 with no wrap; alternating 2047/−2048 gives steady −1 (truncating).
- Gapped input: in_valid pattern 1,0,0,1,1,0,1 with values 16,32,48,64 -> exactly 4 out_valid pulses (1,3,6,10), each 2 cycles after its accept; out_data holds between pulses.
- Clear: after 20 samples of 500, assert clear together with in_valid (value 999) -> 999 dropped, no pending out_valid, outputs 0, settled=0; the next sample 160 gives out=10.
- Rounding: single 8 then zeros:
  - truncating build outputs 0;
  - MOVAVG_ROUND_EN build outputs 1;
  - with −8, outputs −1 truncating and 0 rounded;
  - 16×2047 with MOVAVG_ROUND_EN still outputs 2047, with no overflow.
